// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: CPU MEM stage vs DMA/debug loader.
// Fixed CPU priority with a DMA anti-starvation force. Optional DMA lock via DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  input  logic [2:0]            dma_funct3,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                  dma_lock,
`endif
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  // state  | meaning
  // IDLE   | no read data returning this cycle
  // CPU_RD | CPU load issued last cycle, cpu_rdata valid
  // DMA_RD | DMA load issued last cycle, dma_rdata valid
  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve;
  logic       force_dma;
  logic       lock_hold;

`ifdef DMEM_ARB_LOCK_EN
  logic dma_gnt_q;
  assign lock_hold = dma_gnt_q & dma_req & dma_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Grants are suppressed while reset is asserted so memory sees no access.
  assign force_dma = dma_req & (starve == STARVE_LIM);
  assign dma_gnt   = !reset & dma_req & (!cpu_req | force_dma | lock_hold);
  assign cpu_gnt   = !reset & cpu_req & !dma_gnt;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;
    if (cpu_gnt) begin
      mem_read   = !cpu_we;
      mem_write  = cpu_we;
      mem_a      = cpu_addr;
      mem_wd     = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end else if (dma_gnt) begin
      mem_read   = !dma_we;
      mem_write  = dma_we;
      mem_a      = dma_addr;
      mem_wd     = dma_wdata;
      mem_funct3 = dma_funct3;
    end
  end

  assign cpu_rvalid = (state == CPU_RD);
  assign dma_rvalid = (state == DMA_RD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      starve    <= 4'd0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
`ifdef DMEM_ARB_LOCK_EN
      dma_gnt_q <= 1'b0;
`endif
    end else begin
      if (dma_req && !dma_gnt) begin
        if (starve != STARVE_LIM) starve <= starve + 4'd1;
      end else begin
        starve <= 4'd0;
      end

      if (cpu_gnt && !cpu_we) begin
        state     <= CPU_RD;
        cpu_rdata <= mem_rd;
      end else if (dma_gnt && !dma_we) begin
        state     <= DMA_RD;
        dma_rdata <= mem_rd;
      end else begin
        state <= IDLE;
      end
`ifdef DMEM_ARB_LOCK_EN
      dma_gnt_q <= dma_gnt;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read returns into per-port
// queues; a negedge monitor pops and compares whenever rvalid is (or should be) high.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [8:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic [2:0]  cpu_funct3, dma_funct3;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_a;
  logic [31:0] mem_wd, mem_rd;
  logic [2:0]  mem_funct3;
`ifdef DMEM_ARB_LOCK_EN
  logic        dma_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_funct3(dma_funct3),
`ifdef DMEM_ARB_LOCK_EN
    .dma_lock(dma_lock),
`endif
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // Little-endian data memory model with sign-extending byte/half loads.
  logic [31:0] mem [0:127];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_word = mem[mem_a[8:2]];
    rd_byte = 8'(rd_word >> {mem_a[1:0], 3'b000});
    rd_half = 16'(rd_word >> {mem_a[1], 4'b0000});
    case (mem_funct3)
      3'b000:  mem_rd = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  mem_rd = {{16{rd_half[15]}}, rd_half};
      3'b010:  mem_rd = rd_word;
      default: mem_rd = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      mem[8] <= 32'h11223344;
    end else if (mem_write) begin
      case (mem_funct3)
        3'b000:  mem[mem_a[8:2]][{mem_a[1:0], 3'b000} +: 8]  <= mem_wd[7:0];
        3'b001:  mem[mem_a[8:2]][{mem_a[1], 4'b0000} +: 16] <= mem_wd[15:0];
        3'b010:  mem[mem_a[8:2]] <= mem_wd;
        default: ;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t cpu_q[$];
  exp_t dma_q[$];

  always @(negedge clk) begin
    logic ce, de;
    while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
      chk("cpu_rvalid_missed", 32'(0), 32'(1));
      void'(cpu_q.pop_front());
    end
    while (dma_q.size() > 0 && dma_q[0].cyc < cyc) begin
      chk("dma_rvalid_missed", 32'(0), 32'(1));
      void'(dma_q.pop_front());
    end
    ce = cpu_q.size() > 0 && cpu_q[0].cyc == cyc;
    de = dma_q.size() > 0 && dma_q[0].cyc == cyc;
    if (ce || cpu_rvalid) begin
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ce));
      if (ce) begin
        chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
        void'(cpu_q.pop_front());
      end
    end
    if (de || dma_rvalid) begin
      chk("dma_rvalid", 32'(dma_rvalid), 32'(de));
      if (de) begin
        chk("dma_rdata", dma_rdata, dma_q[0].data);
        void'(dma_q.pop_front());
      end
    end
  end

  // One clock cycle: drive both ports, check grants and memory drive, queue expected reads.
  task automatic step(input string nm,
                      input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cwd,
                      input logic [2:0] cf,
                      input logic dr, input logic dw, input logic [8:0] da, input logic [31:0] dwd,
                      input logic [2:0] df,
                      input logic ecg, input logic edg, input logic [31:0] ecd, input logic [31:0] edd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd; cpu_funct3 = cf;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dwd; dma_funct3 = df;
    @(negedge clk);
    chk({nm, ".cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
    chk({nm, ".dma_gnt"}, 32'(dma_gnt), 32'(edg));
    if (ecg) begin
      chk({nm, ".mem_a"}, 32'(mem_a), 32'(ca));
      chk({nm, ".mem_rw"}, {30'b0, mem_read, mem_write}, {30'b0, !cw, cw});
      chk({nm, ".mem_f3"}, 32'(mem_funct3), 32'(cf));
      if (cw) chk({nm, ".mem_wd"}, mem_wd, cwd);
      else cpu_q.push_back('{cyc + 1, ecd});
    end else if (edg) begin
      chk({nm, ".mem_a"}, 32'(mem_a), 32'(da));
      chk({nm, ".mem_rw"}, {30'b0, mem_read, mem_write}, {30'b0, !dw, dw});
      chk({nm, ".mem_f3"}, 32'(mem_funct3), 32'(df));
      if (dw) chk({nm, ".mem_wd"}, mem_wd, dwd);
      else dma_q.push_back('{cyc + 1, edd});
    end else begin
      chk({nm, ".mem_rw_idle"}, {30'b0, mem_read, mem_write}, 32'h0);
      chk({nm, ".mem_a_idle"}, 32'(mem_a), 32'h0);
      chk({nm, ".mem_wd_idle"}, mem_wd, 32'h0);
      chk({nm, ".mem_f3_idle"}, 32'(mem_funct3), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, 9'h0, 32'h0, 3'b000, 0, 0, 9'h0, 32'h0, 3'b000, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_funct3 = '0;
    @(posedge clk); #1;
    // Requests during reset must not be granted.
    for (int i = 0; i < 2; i++)
      step("rst_gnt", 1, 1, 9'h010, 32'h5555_5555, 3'b010, 1, 1, 9'h020, 32'h6666_6666, 3'b010,
           0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);

    // CPU-only store then load.
    step("t1_st", 1, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 32'h0, 32'h0);
    step("t1_ld", 1, 0, 9'h010, 32'h0, 3'b010, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 32'hDEADBEEF, 32'h0);
    idle("t1_idle");

    // DMA byte load.
    step("t3_ld", 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 9'h020, 32'h0, 3'b000, 0, 1, 32'h0, 32'h00000044);
    idle("t3_idle");

    // Back-to-back CPU then DMA loads.
    step("t4_cpu", 1, 0, 9'h020, 32'h0, 3'b010, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 32'h11223344, 32'h0);
    step("t4_dma", 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 9'h010, 32'h0, 3'b010, 0, 1, 32'h0, 32'hDEADBEEF);
    chk("cpu_rdata_hold", cpu_rdata, 32'h11223344);
    idle("t4_idle");

    // Sub-word store, half load, unsupported funct3.
    step("dma_sb", 0, 0, 9'h0, 32'h0, 3'b000, 1, 1, 9'h011, 32'h000000AB, 3'b000, 0, 1, 32'h0, 32'h0);
    step("cpu_lw", 1, 0, 9'h010, 32'h0, 3'b010, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 32'hDEADABEF, 32'h0);
    step("dma_lh", 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 9'h022, 32'h0, 3'b001, 0, 1, 32'h0, 32'h00001122);
    step("cpu_f3u", 1, 0, 9'h010, 32'h0, 3'b011, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 32'h0, 32'h0);
    idle("x_idle");

    // Continuous contention: CPU x4, DMA x1, repeating.
    for (int i = 0; i < 10; i++)
      step("t2_cont", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010,
           (i % 5) != 4, (i % 5) == 4, 32'h11223344, 32'hDEADABEF);

    // Reset right after a granted CPU load with the starve counter at 3.
    for (int i = 0; i < 3; i++)
      step("t5_pre", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010,
           1, 0, 32'h11223344, 32'h0);
    reset = 1'b1;
    step("t5_rst", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("t5_cpu_rdata", cpu_rdata, 32'h0);
    for (int i = 0; i < 5; i++)
      step("t5_cont", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010,
           i != 4, i == 4, 32'h11223344, 32'hDEADABEF);
    idle("t5_idle");

`ifdef DMEM_ARB_LOCK_EN
    dma_lock = 1'b1;
    step("t6_first", 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 9'h010, 32'h0, 3'b010, 0, 1, 32'h0, 32'hDEADABEF);
    for (int i = 0; i < 3; i++)
      step("t6_lock", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010,
           0, 1, 32'h0, 32'hDEADABEF);
    dma_lock = 1'b0;
    step("t6_rel", 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0, 3'b010,
         1, 0, 32'h11223344, 32'h0);
    idle("t6_idle");
`endif

    idle("drain0");
    idle("drain1");
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'h0);
    chk("dma_q_empty", 32'(dma_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
